handshake_cmpi_pipe: RTL and testbench
======================================

# handshake_cmpi_pipe

Parametrised, pipelined integer comparator with elastic valid/ready handshaking for dataflow circuits. It joins two operand channels and evaluates one of ten compile-time predicates, signed or unsigned, on operands of configurable width. The 1-bit result passes through `STAGES` elastic register slots. It is the drop-in successor of the single-predicate, zero-latency comparator and sits wherever the dataflow graph needs a registered compare to break long combinational paths.

## Interface
- `DATA_TYPE`, 32: operand width in bits, 1..64.
- `PREDICATE`, 2: 0 EQ, 1 NE, 2 SLT, 3 SLE, 4 SGT, 5 SGE, 6 ULT, 7 ULE, 8 UGT, 9 UGE. Any other value is an elaboration `$error`.
- `STAGES`, 1: number of elastic register slots, 1..4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `lhs` in `DATA_TYPE`: left operand.
- `lhs_valid` in 1: left operand valid.
- `lhs_ready` out 1: left operand accepted.
- `rhs` in `DATA_TYPE`: right operand.
- `rhs_valid` in 1: right operand valid.
- `rhs_ready` out 1: right operand accepted.
- `result` out 1: comparison outcome, 1 = predicate true.
- `result_valid` out 1: result valid.
- `result_ready` in 1: downstream accepts result.

## Operation
- **Join**
  - `in_ready` is the ready of slot 0.
  - `lhs_ready = rhs_valid & in_ready`.
  - `rhs_ready = lhs_valid & in_ready`.
  - Fire: `lhs_valid & rhs_valid & in_ready`. Both operands are consumed in the same cycle; neither is consumed alone.
- **Compare**
  - Evaluated combinationally on `lhs`/`rhs` at slot 0 input.
  - Signed predicates treat bit `DATA_TYPE-1` as the sign bit. Unsigned predicates compare the raw bit patterns.
  - Only the 1-bit outcome is stored; operands are never registered.
- **Slot i** holds `v[i]` and `d[i]`.
  - `ready[i] = ~v[i] | ready[i+1]`, with `ready[STAGES] = result_ready`.
  - On a cycle where `ready[i]` is high: `v[i] <= v_in`, `d[i] <= d_in`, where `v_in`/`d_in` come from the previous slot or from the join fire.
  - A slot holding valid data with `ready[i]` low keeps its contents.
- **Outputs:** `result = d[STAGES-1]`, `result_valid = v[STAGES-1]`.
- **Capacity:** `STAGES` tokens in flight, with no bubbles at steady state.
- **Ordering:** results leave in acceptance order; no reordering, no drops, no duplication.
- **Reset values**
  - All `v = 0`, all `d = 0`, so `result = 0` and `result_valid = 0`.
  - The ready outputs remain combinational. Slots are empty, so `lhs_ready = rhs_valid` and `rhs_ready = lhs_valid`.
  - Reset asserted mid-operation discards all in-flight tokens. The join does not fire during a reset cycle.

## Timing
- **Latency:** an operand pair fired at edge N appears on `result_valid` after edge N+STAGES-1, i.e. `STAGES` cycles from acceptance to first visibility.
- **Throughput:** 1 result per cycle while `result_ready` stays high.
- **Stall:** with `result_ready` low, the pipeline fills. After `STAGES` accepted tokens, `in_ready` drops in the same cycle the last slot is full and the chain ahead is full.
- **Simultaneous events:** a full slot emitting and receiving in the same cycle is legal and keeps throughput.
- **Combinational paths:** `result_ready -> lhs_ready/rhs_ready` through the ready chain, and `lhs_valid <-> rhs_ready` via the join. No valid-to-valid path.

## Configuration
- **`HANDSHAKE_CMPI_SKID_EN` defined:** a one-entry skid register is inserted between the last slot and the output.
  - The last slot's ready becomes the registered `~skid_full`, which cuts the `result_ready -> lhs_ready` combinational path.
  - Capacity is `STAGES+1`. Latency is unchanged when the skid is empty.
  - The skid resets empty. When the skid is full, output comes from the skid.
- **Undefined:** no skid; behaviour exactly as above.

## Structure
- **Package `handshake_cmpi_pkg`:** predicate encoding localparams (`CMPI_EQ` .. `CMPI_UGE`), plus a function `cmpi_eval(pred, lhs, rhs)` parameterised by width via a 64-bit sign/zero-extended form.
- **Sub-module `elastic_slot_1b`:** one valid/data/ready register slot, instantiated `STAGES` times in a generate loop. The skid buffer is a second `generate` branch in the top level.

## Test plan
- **Basic SLT, STAGES=1:** `lhs=0xFFFFFFFF`, `rhs=1`, both valid, `result_ready=1` -> `result=1` one cycle later. The same pair with PREDICATE=6 (ULT) gives `result=0`.
- **Join:** `lhs_valid` held high with `rhs_valid=0` for 5 cycles -> `lhs_ready=0` and no fire. `rhs_valid` rises -> both readies high the same cycle; exactly one token is accepted.
- **Backpressure, STAGES=3:** stream 6 pairs (EQ, `lhs=rhs` on even indices) with `result_ready=0` -> `in_ready` drops after 3 accepts (4 with skid). Release -> results arrive in order 1,0,1,0,1,0 with no loss.
- **Full throughput, STAGES=4:** 100 back-to-back pairs with `result_ready=1` -> 100 results in 103 cycles after the first accept.
- **Reset mid-flight:** 2 tokens in flight, `rst=1` for one cycle -> `result_valid=0` the next cycle and no stale token is emitted afterward.
- **Boundary, DATA_TYPE=8, SGE:** `lhs=0x80`, `rhs=0x7F` -> `result=0`. UGE on the same pair -> `result=1`. Equal operands -> SLE=1, SGT=0.

Source files
------------

// File: rtl/handshake_cmpi_pkg.sv
// Predicate encoding and the width-generic compare shared by the comparator pipeline.
// Operands arrive zero-extended to 64 bits; cmpi_eval applies sign extension itself.
package handshake_cmpi_pkg;

    localparam int CMPI_EQ  = 0;
    localparam int CMPI_NE  = 1;
    localparam int CMPI_SLT = 2;
    localparam int CMPI_SLE = 3;
    localparam int CMPI_SGT = 4;
    localparam int CMPI_SGE = 5;
    localparam int CMPI_ULT = 6;
    localparam int CMPI_ULE = 7;
    localparam int CMPI_UGT = 8;
    localparam int CMPI_UGE = 9;

    function automatic logic cmpi_eval(
        input int          pred,
        input int          width,
        input logic [63:0] lhs,
        input logic [63:0] rhs
    );
        logic [63:0] mask;
        logic [63:0] sbit;
        logic [63:0] lz;
        logic [63:0] rz;
        logic [63:0] ls;
        logic [63:0] rs;
        logic        res;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sbit = 64'd1 << (width - 1);
        lz   = lhs & mask;
        rz   = rhs & mask;
        // Signed forms: replicate the operand's top bit into every bit above it.
        ls   = ((lz & sbit) != '0) ? (lz | ~mask) : lz;
        rs   = ((rz & sbit) != '0) ? (rz | ~mask) : rz;
        case (pred)
            CMPI_EQ:  res = (lz == rz);
            CMPI_NE:  res = (lz != rz);
            CMPI_SLT: res = ($signed(ls) <  $signed(rs));
            CMPI_SLE: res = ($signed(ls) <= $signed(rs));
            CMPI_SGT: res = ($signed(ls) >  $signed(rs));
            CMPI_SGE: res = ($signed(ls) >= $signed(rs));
            CMPI_ULT: res = (lz <  rz);
            CMPI_ULE: res = (lz <= rz);
            CMPI_UGT: res = (lz >  rz);
            CMPI_UGE: res = (lz >= rz);
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/elastic_slot_1b.sv
// One valid/data register slot of the result pipeline; loads whenever its ready (i_ld) is high.
// Holds its contents while full and not ready; the ready chain itself is built by the parent.
module elastic_slot_1b
    import handshake_cmpi_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ld,
    input  logic i_vld,
    input  logic i_dat,
    output logic o_vld,
    output logic o_dat
);

    logic r_vld;
    logic r_dat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_dat <= 1'b0;
        end else if (i_ld) begin
            r_vld <= i_vld;
            r_dat <= i_dat;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/handshake_cmpi_pipe.sv
// Joined two-operand compare, result carried through STAGES elastic slots (STAGES cycles fire-to-valid).
// Readies are combinational from result_ready; HANDSHAKE_CMPI_SKID_EN adds an output skid that registers the last ready.
module handshake_cmpi_pipe
    import handshake_cmpi_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int PREDICATE = CMPI_SLT,
    parameter int STAGES    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic                 result,
    output logic                 result_valid,
    input  logic                 result_ready
);

`ifdef HANDSHAKE_CMPI_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    if (PREDICATE < CMPI_EQ || PREDICATE > CMPI_UGE ||
        DATA_TYPE < 1 || DATA_TYPE > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_cfg
        $error("handshake_cmpi_pipe: unsupported PREDICATE, DATA_TYPE or STAGES");
    end

    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_d;
    logic [STAGES:0]   w_rdy;
    logic              w_out_rdy;
    logic              w_fire;
    logic              w_cmp;

    assign w_cmp     = cmpi_eval(PREDICATE, DATA_TYPE, 64'(lhs), 64'(rhs));
    assign lhs_ready = rhs_valid & w_rdy[0];
    assign rhs_ready = lhs_valid & w_rdy[0];
    assign w_fire    = lhs_valid & rhs_valid & w_rdy[0];

    // Built back-to-front in one process so the chain is a plain combinational sweep.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = w_out_rdy;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_v[i] | w_rdy[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic w_in_vld;
        logic w_in_dat;
        if (i == 0) begin : g_head
            assign w_in_vld = w_fire;
            assign w_in_dat = w_cmp;
        end else begin : g_link
            assign w_in_vld = w_v[i-1];
            assign w_in_dat = w_d[i-1];
        end
        elastic_slot_1b u_slot (
            .i_clk (clk),
            .i_rst (rst),
            .i_ld  (w_rdy[i]),
            .i_vld (w_in_vld),
            .i_dat (w_in_dat),
            .o_vld (w_v[i]),
            .o_dat (w_d[i])
        );
    end

    if (SKID_EN) begin : g_skid
        logic r_skid_full;
        logic r_skid_dat;
        // The skid catches the last slot's token only when downstream refuses it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_skid_full <= 1'b0;
                r_skid_dat  <= 1'b0;
            end else if (r_skid_full) begin
                if (result_ready) begin
                    r_skid_full <= 1'b0;
                end
            end else if (w_v[STAGES-1] && !result_ready) begin
                r_skid_full <= 1'b1;
                r_skid_dat  <= w_d[STAGES-1];
            end
        end
        assign w_out_rdy    = ~r_skid_full;
        assign result_valid = r_skid_full | w_v[STAGES-1];
        assign result       = r_skid_full ? r_skid_dat : w_d[STAGES-1];
    end else begin : g_direct
        assign w_out_rdy    = result_ready;
        assign result_valid = w_v[STAGES-1];
        assign result       = w_d[STAGES-1];
    end

endmodule

// File: tb/tb_handshake_cmpi_pipe.sv
// Directed bench for handshake_cmpi_pipe across several predicate/width/depth configurations.
module tb_handshake_cmpi_pipe;
    import handshake_cmpi_pkg::*;

`ifdef HANDSHAKE_CMPI_SKID_EN
    localparam int BP_CAP = 4;
`else
    localparam int BP_CAP = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Group A: 32-bit, STAGES=1, SLT and ULT on shared operands
    logic [31:0] a_lhs, a_rhs;
    logic        a_lv, a_rv, a_rr;
    logic        slt_lrdy, slt_rrdy, slt_res, slt_vld;
    logic        ult_lrdy, ult_rrdy, ult_res, ult_vld;
    // Group B: 32-bit EQ, STAGES=3 (backpressure, reset mid-flight)
    logic [31:0] b_lhs, b_rhs;
    logic        b_lv, b_rv, b_rr;
    logic        b_lrdy, b_rrdy, b_res, b_vld;
    // Group C: 32-bit EQ, STAGES=4 (throughput)
    logic [31:0] c_lhs, c_rhs;
    logic        c_lv, c_rv, c_rr;
    logic        c_lrdy, c_rrdy, c_res, c_vld;
    // Group D: 8-bit, STAGES=1, SGE/UGE/SLE/SGT on shared operands
    logic [7:0]  d_lhs, d_rhs;
    logic        d_lv, d_rv, d_rr;
    logic        sge_lrdy, sge_rrdy, sge_res, sge_vld;
    logic        uge_lrdy, uge_rrdy, uge_res, uge_vld;
    logic        sle_lrdy, sle_rrdy, sle_res, sle_vld;
    logic        sgt_lrdy, sgt_rrdy, sgt_res, sgt_vld;

    handshake_cmpi_pipe #(.DATA_TYPE(32), .PREDICATE(CMPI_SLT), .STAGES(1)) u_slt (
        .clk(clk), .rst(rst), .lhs(a_lhs), .lhs_valid(a_lv), .lhs_ready(slt_lrdy),
        .rhs(a_rhs), .rhs_valid(a_rv), .rhs_ready(slt_rrdy),
        .result(slt_res), .result_valid(slt_vld), .result_ready(a_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(32), .PREDICATE(CMPI_ULT), .STAGES(1)) u_ult (
        .clk(clk), .rst(rst), .lhs(a_lhs), .lhs_valid(a_lv), .lhs_ready(ult_lrdy),
        .rhs(a_rhs), .rhs_valid(a_rv), .rhs_ready(ult_rrdy),
        .result(ult_res), .result_valid(ult_vld), .result_ready(a_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(32), .PREDICATE(CMPI_EQ), .STAGES(3)) u_bp (
        .clk(clk), .rst(rst), .lhs(b_lhs), .lhs_valid(b_lv), .lhs_ready(b_lrdy),
        .rhs(b_rhs), .rhs_valid(b_rv), .rhs_ready(b_rrdy),
        .result(b_res), .result_valid(b_vld), .result_ready(b_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(32), .PREDICATE(CMPI_EQ), .STAGES(4)) u_tp (
        .clk(clk), .rst(rst), .lhs(c_lhs), .lhs_valid(c_lv), .lhs_ready(c_lrdy),
        .rhs(c_rhs), .rhs_valid(c_rv), .rhs_ready(c_rrdy),
        .result(c_res), .result_valid(c_vld), .result_ready(c_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(8), .PREDICATE(CMPI_SGE), .STAGES(1)) u_sge (
        .clk(clk), .rst(rst), .lhs(d_lhs), .lhs_valid(d_lv), .lhs_ready(sge_lrdy),
        .rhs(d_rhs), .rhs_valid(d_rv), .rhs_ready(sge_rrdy),
        .result(sge_res), .result_valid(sge_vld), .result_ready(d_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(8), .PREDICATE(CMPI_UGE), .STAGES(1)) u_uge (
        .clk(clk), .rst(rst), .lhs(d_lhs), .lhs_valid(d_lv), .lhs_ready(uge_lrdy),
        .rhs(d_rhs), .rhs_valid(d_rv), .rhs_ready(uge_rrdy),
        .result(uge_res), .result_valid(uge_vld), .result_ready(d_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(8), .PREDICATE(CMPI_SLE), .STAGES(1)) u_sle (
        .clk(clk), .rst(rst), .lhs(d_lhs), .lhs_valid(d_lv), .lhs_ready(sle_lrdy),
        .rhs(d_rhs), .rhs_valid(d_rv), .rhs_ready(sle_rrdy),
        .result(sle_res), .result_valid(sle_vld), .result_ready(d_rr));
    handshake_cmpi_pipe #(.DATA_TYPE(8), .PREDICATE(CMPI_SGT), .STAGES(1)) u_sgt (
        .clk(clk), .rst(rst), .lhs(d_lhs), .lhs_valid(d_lv), .lhs_ready(sgt_lrdy),
        .rhs(d_rhs), .rhs_valid(d_rv), .rhs_ready(sgt_rrdy),
        .result(sgt_res), .result_valid(sgt_vld), .result_ready(d_rr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b_lv = 1'b0;
        b_rv = 1'b1;
        #1;
        checks++;
        if (b_lrdy !== 1'b1 || b_rrdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_readies: got lhs_ready=%b rhs_ready=%b expected 1 0", b_lrdy, b_rrdy);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({b_vld, b_res, c_vld, c_res, slt_vld, slt_res, sge_vld} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {b_vld, b_res, c_vld, c_res, slt_vld, slt_res, sge_vld});
        end
        b_rv = 1'b0;
    endtask

    task automatic test_slt_ult();
        a_lhs = 32'hFFFF_FFFF;
        a_rhs = 32'd1;
        a_lv  = 1'b1;
        a_rv  = 1'b1;
        a_rr  = 1'b1;
        #1;
        checks++;
        if ({slt_lrdy, slt_rrdy, ult_lrdy, ult_rrdy} !== 4'b1111) begin
            errors++;
            $display("FAIL slt_readies: got %b expected 1111", {slt_lrdy, slt_rrdy, ult_lrdy, ult_rrdy});
        end
        step();
        a_lv = 1'b0;
        a_rv = 1'b0;
        checks++;
        if (slt_vld !== 1'b1 || slt_res !== 1'b1) begin
            errors++;
            $display("FAIL slt_result: got vld=%b res=%b expected 1 1", slt_vld, slt_res);
        end
        checks++;
        if (ult_vld !== 1'b1 || ult_res !== 1'b0) begin
            errors++;
            $display("FAIL ult_result: got vld=%b res=%b expected 1 0", ult_vld, ult_res);
        end
        step();
        checks++;
        if (slt_vld !== 1'b0) begin
            errors++;
            $display("FAIL slt_drained: got vld=%b expected 0", slt_vld);
        end
    endtask

    task automatic test_join();
        a_lhs = 32'd5;
        a_rhs = 32'd3;
        a_lv  = 1'b1;
        a_rv  = 1'b0;
        a_rr  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (slt_lrdy !== 1'b0 || slt_vld !== 1'b0) begin
                errors++;
                $display("FAIL join_wait cycle %0d: got lhs_ready=%b vld=%b expected 0 0", k, slt_lrdy, slt_vld);
            end
            step();
        end
        a_rv = 1'b1;
        #1;
        checks++;
        if (slt_lrdy !== 1'b1 || slt_rrdy !== 1'b1) begin
            errors++;
            $display("FAIL join_fire: got lhs_ready=%b rhs_ready=%b expected 1 1", slt_lrdy, slt_rrdy);
        end
        step();
        a_lv = 1'b0;
        a_rv = 1'b0;
        checks++;
        if (slt_vld !== 1'b1 || slt_res !== 1'b0) begin
            errors++;
            $display("FAIL join_result: got vld=%b res=%b expected 1 0", slt_vld, slt_res);
        end
        step();
        checks++;
        if (slt_vld !== 1'b0) begin
            errors++;
            $display("FAIL join_single: got vld=%b expected 0", slt_vld);
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        int   got;
        bit   stalled;
        logic exp_r;
        acc     = 0;
        got     = 0;
        stalled = 1'b0;
        b_rr    = 1'b0;
        for (int cyc = 0; cyc < 12 && !stalled; cyc++) begin
            b_lhs = 32'(acc * 3 + 10);
            b_rhs = (acc % 2 == 0) ? b_lhs : b_lhs + 32'd1;
            b_lv  = 1'b1;
            b_rv  = 1'b1;
            #1;
            if (b_lrdy) begin
                acc++;
                step();
            end else begin
                stalled = 1'b1;
            end
        end
        checks++;
        if (acc != BP_CAP) begin
            errors++;
            $display("FAIL bp_capacity: got %0d accepts expected %0d", acc, BP_CAP);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (b_lrdy !== 1'b0 || b_vld !== 1'b1 || b_res !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got rdy=%b vld=%b res=%b expected 0 1 1", k, b_lrdy, b_vld, b_res);
            end
        end
        b_rr = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            b_lv  = (acc < 6);
            b_rv  = (acc < 6);
            b_lhs = 32'(acc * 3 + 10);
            b_rhs = (acc % 2 == 0) ? b_lhs : b_lhs + 32'd1;
            #1;
            if (b_vld) begin
                exp_r = (got % 2 == 0);
                checks++;
                if (b_res !== exp_r) begin
                    errors++;
                    $display("FAIL bp_order result %0d: got %b expected %b", got, b_res, exp_r);
                end
                got++;
            end
            if (b_lrdy && b_lv) acc++;
            @(posedge clk);
            #1;
        end
        b_lv = 1'b0;
        b_rv = 1'b0;
        checks++;
        if (got != 6 || acc != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results %0d accepts expected 6 6", got, acc);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (b_vld !== 1'b0) begin
                errors++;
                $display("FAIL bp_no_extra cycle %0d: got vld=%b expected 0", k, b_vld);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen  = 0;
        b_rr  = 1'b0;
        b_lhs = 32'h1234;
        b_rhs = 32'h1234;
        b_lv  = 1'b1;
        b_rv  = 1'b1;
        step();
        step();
        b_lv = 1'b0;
        b_rv = 1'b0;
        step();
        checks++;
        if (b_vld !== 1'b1) begin
            errors++;
            $display("FAIL midflight_loaded: got vld=%b expected 1", b_vld);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (b_vld !== 1'b0 || b_res !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: got vld=%b res=%b expected 0 0", b_vld, b_res);
        end
        b_rr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (b_vld) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d stale results expected 0", seen);
        end
    endtask

    task automatic test_throughput();
        int   acc;
        int   got;
        int   e0;
        int   elastacc;
        int   elast;
        logic exp_r;
        acc      = 0;
        got      = 0;
        e0       = -1;
        elastacc = -1;
        elast    = -1;
        c_rr     = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            c_lv  = (acc < 100);
            c_rv  = (acc < 100);
            c_lhs = 32'(acc * 5);
            c_rhs = (acc % 3 == 0) ? c_lhs : c_lhs + 32'd2;
            #1;
            if (c_vld) begin
                exp_r = (got % 3 == 0);
                checks++;
                if (c_res !== exp_r) begin
                    errors++;
                    $display("FAIL tp_value result %0d: got %b expected %b", got, c_res, exp_r);
                end
                got++;
                if (got == 100) elast = cyc;
            end
            if (c_lrdy && c_lv) begin
                if (acc == 0) e0 = cyc;
                acc++;
                if (acc == 100) elastacc = cyc;
            end
            @(posedge clk);
            #1;
        end
        c_lv = 1'b0;
        c_rv = 1'b0;
        checks++;
        if (got != 100 || elast - e0 != 103) begin
            errors++;
            $display("FAIL tp_cycles: got %0d results in %0d cycles expected 100 in 103", got, elast - e0);
        end
        checks++;
        if (elastacc - e0 != 99) begin
            errors++;
            $display("FAIL tp_accept_rate: got span %0d expected 99", elastacc - e0);
        end
    endtask

    task automatic test_boundary8();
        d_rr  = 1'b1;
        d_lhs = 8'h80;
        d_rhs = 8'h7F;
        d_lv  = 1'b1;
        d_rv  = 1'b1;
        #1;
        checks++;
        if ({sge_lrdy, uge_lrdy, sle_lrdy, sgt_lrdy, sge_rrdy, uge_rrdy, sle_rrdy, sgt_rrdy} !== 8'hFF) begin
            errors++;
            $display("FAIL b8_readies: got %b expected 11111111",
                     {sge_lrdy, uge_lrdy, sle_lrdy, sgt_lrdy, sge_rrdy, uge_rrdy, sle_rrdy, sgt_rrdy});
        end
        step();
        checks++;
        if ({sge_vld, sge_res, uge_vld, uge_res, sle_res, sgt_res} !== 6'b101110) begin
            errors++;
            $display("FAIL b8_80_vs_7f: got %b expected 101110",
                     {sge_vld, sge_res, uge_vld, uge_res, sle_res, sgt_res});
        end
        d_lhs = 8'h80;
        d_rhs = 8'h80;
        step();
        checks++;
        if ({sle_vld, sle_res, sgt_vld, sgt_res, sge_res, uge_res} !== 6'b111011) begin
            errors++;
            $display("FAIL b8_equal: got %b expected 111011",
                     {sle_vld, sle_res, sgt_vld, sgt_res, sge_res, uge_res});
        end
        d_lhs = 8'h7F;
        d_rhs = 8'h80;
        step();
        d_lv = 1'b0;
        d_rv = 1'b0;
        checks++;
        if ({sgt_res, sle_res, sge_res, uge_res} !== 4'b1010) begin
            errors++;
            $display("FAIL b8_7f_vs_80: got %b expected 1010", {sgt_res, sle_res, sge_res, uge_res});
        end
        step();
        checks++;
        if ({sge_vld, uge_vld, sle_vld, sgt_vld} !== 4'b0000) begin
            errors++;
            $display("FAIL b8_drained: got %b expected 0000", {sge_vld, uge_vld, sle_vld, sgt_vld});
        end
    endtask

    initial begin
        rst   = 1'b1;
        a_lhs = '0; a_rhs = '0; a_lv = 1'b0; a_rv = 1'b0; a_rr = 1'b0;
        b_lhs = '0; b_rhs = '0; b_lv = 1'b0; b_rv = 1'b0; b_rr = 1'b0;
        c_lhs = '0; c_rhs = '0; c_lv = 1'b0; c_rv = 1'b0; c_rr = 1'b0;
        d_lhs = '0; d_rhs = '0; d_lv = 1'b0; d_rv = 1'b0; d_rr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_slt_ult();
        test_join();
        test_backpressure();
        test_reset_midflight();
        test_throughput();
        test_boundary8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
